bus_rr_arbiter: RTL and testbench
=================================

# bus_rr_arbiter

Round-robin arbiter that shares the tagged-data D flip-flop stage among `N_REQ` requesters. Each cycle it selects at most one pending requester and drives that requester's `Bus_t` word onto the register's enable/data inputs. Its `o_E`/`o_D` outputs connect directly to the flip-flop's `i_E`/`i_D`. An idle cycle therefore loads zero, matching the register's clear-on-disable behaviour.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `GAP`, default 0: minimum idle cycles inserted after every grant, 0..15.

- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_req`  in  `N_REQ`  per-requester "word pending" level.
- `i_data`  in  `N_REQ` x `Bus_t`  packed array; entry k is requester k's word.
- `o_gnt`  out  `N_REQ`  one-hot grant; registered.
- `o_E`  out  1  enable to register stage; registered.
- `o_D`  out  `Bus_t`  word to register stage; registered.
- `o_busy`  out  1  high in GRANT or GAP state.

## Operation
- State machine states: IDLE, GRANT, GAP.
- Reset values:
  - `o_gnt` = 0, `o_E` = 0, `o_D` = 0, `o_busy` = 0.
  - State = IDLE.
  - Priority pointer `ptr` = 0.
  - Gap counter = 0.
- Effective request vector: `eff = i_req & ~o_gnt`.
  - The requester granted in the current cycle is masked from this edge's arbitration.
  - The same requester is never granted in consecutive cycles.
- Arbitration selects the first set bit of `eff` searching k = `ptr`, `ptr`+1, … mod `N_REQ`.
- IDLE:
  - If `eff` ≠ 0, go to GRANT: `o_gnt` = one-hot(k), `o_E` = 1, `o_D` = `i_data[k]`, `ptr` ← (k+1) mod `N_REQ`.
  - Otherwise outputs stay 0.
- GRANT, when `GAP` = 0:
  - If `eff` ≠ 0, re-arbitrate and stay in GRANT.
  - Else go to IDLE with `o_gnt`/`o_E`/`o_D` = 0.
- GRANT, when `GAP` > 0:
  - Go to GAP; load counter = `GAP`-1.
  - `o_gnt`/`o_E`/`o_D` = 0.
- GAP:
  - Decrement the counter each cycle; no grants are issued.
  - When the counter is 0: if `eff` ≠ 0, go to GRANT (arbitrate as in IDLE), else go to IDLE.
- Whenever `o_E` = 0, `o_D` is forced to 0.
- Requester obligations:
  - Hold `i_req` and `i_data[k]` stable from assertion until it observes `o_gnt[k]`.
  - Deassert `i_req[k]`, or present a new word, by the edge ending its grant cycle.
- `i_req` dropping before grant withdraws the request with no side effect.

## Timing
- Request sampled at edge n → `o_gnt`/`o_E`/`o_D` valid in cycle n+1.
- The register's `o_Q` reflects the word in cycle n+2.
- Throughput:
  - `GAP` = 0 with ≥2 requesters: one word per cycle.
  - Single requester: one word every 2 cycles, due to the grant mask.
- `GAP` = G > 0: at most one grant per G+1 cycles.
- Fairness: a continuously requesting requester waits at most `N_REQ`-1 grants.
- Simultaneous requests: resolved by `ptr` order only; there is no fixed priority.
- Reset mid-operation:
  - The next cycle has all outputs 0, state IDLE and `ptr` = 0.
  - An in-flight grant is not repeated. A requester whose grant was aborted keeps requesting and is re-arbitrated.
- `ptr` wraps from `N_REQ`-1 to 0.

## Configuration
- Macro: `BUS_RR_ARB_TAG_STAMP_EN`.
- Defined:
  - On grant, the tag field of `o_D` is replaced by requester index k, zero-extended to the tag width.
  - The data field is passed unchanged.
  - The tag width must be ≥ clog2(`N_REQ`). Elaboration fails otherwise.
- Undefined: `o_D` = `i_data[k]` verbatim.

## Test plan
- Reset priority, `GAP` = 0:
  - Stimulus: reset, then `i_req` = 4'b1111 held for 4 cycles, distinct `i_data` per requester.
  - Response: `o_gnt` sequence 0001, 0010, 0100, 1000 in consecutive cycles; `o_D` matches each requester's word; `o_E` = 1 throughout.
- Single requester:
  - Stimulus: only `i_req[2]` held high for 6 cycles with `i_data[2]` = 12'hA5C.
  - Response: `o_gnt` = 0100 on alternating cycles (3 grants); `o_D` = 12'hA5C only on grant cycles, 0 otherwise.
- Gap spacing:
  - Stimulus: `GAP` = 2, `i_req` = 4'b0011 held.
  - Response: grants to 0 and 1 alternate, each followed by exactly 2 cycles with `o_E` = 0 and `o_busy` = 1.
- Reset mid-operation:
  - Stimulus: assert `i_rst` during a grant to requester 3.
  - Response: next cycle `o_gnt` = 0 and `o_D` = 0; after release, requester 0 (if requesting) is granted before requester 3.
- Tag stamp (with macro):
  - Stimulus: requester 1 issues a word with tag = 0 and data = D.
  - Response: `o_D` carries tag = 1 and data = D. Without the macro, tag = 0.
- Fairness:
  - Stimulus: random `i_req` for 10,000 cycles.
  - Response (checked by monitor):
    - Grants are always one-hot.
    - No requester is granted twice in a row.
    - No requester waits more than `N_REQ`-1 grants while requesting.

Source files
------------

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter feeding the tagged-data register stage (enable + word).
// Optional BUS_RR_ARB_TAG_STAMP_EN: overwrite the word's tag with the granted requester index.
module bus_rr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int GAP    = 0,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 8
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [N_REQ-1:0]                     i_req,
    input  logic [N_REQ-1:0][TAG_W+DATA_W-1:0]   i_data,
    output logic [N_REQ-1:0]                     o_gnt,
    output logic                                 o_E,
    output logic [TAG_W+DATA_W-1:0]              o_D,
    output logic                                 o_busy
);

    localparam int BUS_W = TAG_W + DATA_W;
    localparam int PTR_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;
    localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);
    localparam logic [PTR_W:0]   N_WIDE   = (PTR_W + 1)'(N_REQ);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } bus_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    if ((N_REQ < 2) || (N_REQ > 8)) begin : g_bad_nreq
        $error("bus_rr_arbiter: N_REQ must be in 2..8");
    end
    if ((GAP < 0) || (GAP > 15)) begin : g_bad_gap
        $error("bus_rr_arbiter: GAP must be in 0..15");
    end
`ifdef BUS_RR_ARB_TAG_STAMP_EN
    if (TAG_W < $clog2(N_REQ)) begin : g_bad_tag
        $error("bus_rr_arbiter: tag field too narrow to hold a requester index");
    end
`endif

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               e_q, e_d;
    logic [BUS_W-1:0]   d_q, d_d;
    logic               busy_q, busy_d;

    logic [N_REQ-1:0]   eff_s;
    logic [PTR_W:0]     sum_s;
    logic [PTR_W-1:0]   pick_s;
    logic               found_s;
    logic               take_s;
    bus_t               word_s;

    assign eff_s = i_req & ~gnt_q;

    // Rotating search from ptr; walking offsets downward lets the smallest offset win.
    always_comb begin
        found_s = 1'b0;
        pick_s  = ptr_q;
        sum_s   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum_s = {1'b0, ptr_q} + (PTR_W + 1)'(i);
            if (sum_s >= N_WIDE) begin
                sum_s = sum_s - N_WIDE;
            end else begin
                sum_s = sum_s;
            end
            if (eff_s[sum_s[PTR_W-1:0]]) begin
                found_s = 1'b1;
                pick_s  = sum_s[PTR_W-1:0];
            end else begin
                found_s = found_s;
                pick_s  = pick_s;
            end
        end
    end

    // Word presented for the selected requester, tag optionally stamped.
    always_comb begin
        word_s = bus_t'(i_data[pick_s]);
`ifdef BUS_RR_ARB_TAG_STAMP_EN
        word_s.tag = TAG_W'(pick_s);
`endif
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        e_d     = 1'b0;
        d_d     = '0;
        take_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    take_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (GAP == 0) begin
                    if (found_s) begin
                        take_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (found_s) begin
                    take_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        if (take_s) begin
            state_d = ST_GRANT;
            gnt_d   = {{(N_REQ - 1){1'b0}}, 1'b1} << pick_s;
            e_d     = 1'b1;
            d_d     = word_s;
            ptr_d   = (pick_s == PTR_LAST) ? '0 : pick_s + PTR_W'(1);
        end else begin
            gnt_d = '0;
            e_d   = 1'b0;
            d_d   = '0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, pointer, counter and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= 4'd0;
            gnt_q   <= '0;
            e_q     <= 1'b0;
            d_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            e_q     <= e_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
        end
    end

    assign o_gnt  = gnt_q;
    assign o_E    = e_q;
    assign o_D    = d_q;
    assign o_busy = busy_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: one GAP=0 instance and one GAP=2 instance.
module tb_bus_rr_arbiter;

    logic             clk;
    logic             rst;
    logic [3:0]       req;
    logic [3:0]       req_g;
    logic [3:0][11:0] data_s;
    logic [3:0]       gnt, gnt_g;
    logic             e, e_g;
    logic [11:0]      d, d_g;
    logic             busy, busy_g;

    int n_chk = 0;
    int n_err = 0;

    logic [3:0]  pg;
    logic [3:0]  preq;
    logic [11:0] pd [4];
    logic [11:0] exp_d;
    logic [3:0]  exp_g;
    logic        exp_e;
    int          wt [4];
    int          worst;
    int          idx;

    bus_rr_arbiter #(.N_REQ(4), .GAP(0), .TAG_W(4), .DATA_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_data(data_s),
        .o_gnt(gnt), .o_E(e), .o_D(d), .o_busy(busy)
    );

    bus_rr_arbiter #(.N_REQ(4), .GAP(2), .TAG_W(4), .DATA_W(8)) dut_g (
        .i_clk(clk), .i_rst(rst), .i_req(req_g), .i_data(data_s),
        .o_gnt(gnt_g), .o_E(e_g), .o_D(d_g), .o_busy(busy_g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] expw(input int k, input logic [11:0] w);
`ifdef BUS_RR_ARB_TAG_STAMP_EN
        return {4'(k), w[7:0]};
`else
        return w;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        req    = 4'b0000;
        req_g  = 4'b0000;
        data_s = '0;
        for (int k = 0; k < 4; k++) wt[k] = 0;
        repeat (2) step();
        chk("rst_gnt",  32'(gnt), 32'h0);
        chk("rst_e",    32'(e), 32'h0);
        chk("rst_d",    32'(d), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_busy_g", 32'(busy_g), 32'h0);
        rst = 1'b0;

        // All four requesting: grants sweep 0..3 from the reset pointer.
        data_s[0] = 12'h1A1;
        data_s[1] = 12'h2B2;
        data_s[2] = 12'h3C3;
        data_s[3] = 12'h4D4;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_gnt", 32'(gnt), 32'(4'b0001 << k));
            chk("rr_e",   32'(e), 32'h1);
            chk("rr_d",   32'(d), 32'(expw(k, data_s[k])));
            chk("rr_busy", 32'(busy), 32'h1);
        end
        req = 4'b0000;
        step();
        chk("idle_gnt",  32'(gnt), 32'h0);
        chk("idle_d",    32'(d), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);

        // Lone requester 2: granted every other cycle.
        data_s[2] = 12'hA5C;
        req = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            step();
            if ((i % 2) == 0) begin
                exp_g = 4'b0100; exp_e = 1'b1; exp_d = expw(2, 12'hA5C);
            end else begin
                exp_g = 4'b0000; exp_e = 1'b0; exp_d = 12'h000;
            end
            chk("single_gnt", 32'(gnt), 32'(exp_g));
            chk("single_e",   32'(e), 32'(exp_e));
            chk("single_d",   32'(d), 32'(exp_d));
        end
        req = 4'b0000;
        step();

        // Pointer sits at 3: grant 3, reset mid-grant, then 0 wins before 3.
        req = 4'b1001;
        step();
        chk("pre_rst_gnt", 32'(gnt), 32'h8);
        rst = 1'b1;
        step();
        chk("mid_rst_gnt",  32'(gnt), 32'h0);
        chk("mid_rst_e",    32'(e), 32'h0);
        chk("mid_rst_d",    32'(d), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        step();
        chk("post_rst_gnt0", 32'(gnt), 32'h1);
        chk("post_rst_d0",   32'(d), 32'(expw(0, data_s[0])));
        step();
        chk("post_rst_gnt3", 32'(gnt), 32'h8);
        chk("post_rst_d3",   32'(d), 32'(expw(3, data_s[3])));
        req = 4'b0000;
        step();

        // Tag handling: requester 1 sends tag 0, data 3C.
        data_s[1] = 12'h03C;
        req = 4'b0010;
        step();
        chk("tag_gnt", 32'(gnt), 32'h2);
`ifdef BUS_RR_ARB_TAG_STAMP_EN
        chk("tag_field", 32'(d[11:8]), 32'h1);
`else
        chk("tag_field", 32'(d[11:8]), 32'h0);
`endif
        chk("tag_data", 32'(d[7:0]), 32'h3C);
        req = 4'b0000;
        step();

        // GAP=2 instance: grant, two idle-but-busy cycles, alternating 0/1.
        req_g = 4'b0011;
        for (int i = 0; i < 9; i++) begin
            step();
            idx = (i / 3) % 2;
            if ((i % 3) == 0) begin
                exp_g = 4'b0001 << idx; exp_e = 1'b1; exp_d = expw(idx, data_s[idx]);
            end else begin
                exp_g = 4'b0000; exp_e = 1'b0; exp_d = 12'h000;
            end
            chk("gap_gnt",  32'(gnt_g), 32'(exp_g));
            chk("gap_e",    32'(e_g), 32'(exp_e));
            chk("gap_d",    32'(d_g), 32'(exp_d));
            chk("gap_busy", 32'(busy_g), 32'h1);
        end
        req_g = 4'b0000;
        step();
        chk("gap_end_busy", 32'(busy_g), 32'h0);

        // Random requests on the GAP=0 instance with fairness bookkeeping.
        for (int c = 0; c < 10000; c++) begin
            req = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) begin
                data_s[k] = 12'($urandom);
                pd[k] = data_s[k];
            end
            preq = req;
            pg = gnt;
            step();
            chk("fair_onehot", 32'($onehot0(gnt)), 32'h1);
            chk("fair_repeat", 32'(gnt & pg), 32'h0);
            chk("fair_e", 32'(e), 32'(|gnt));
            exp_d = 12'h000;
            for (int k = 0; k < 4; k++) begin
                if (gnt[k]) exp_d = expw(k, pd[k]);
            end
            chk("fair_d", 32'(d), 32'(exp_d));
            worst = 0;
            for (int k = 0; k < 4; k++) begin
                if (!preq[k] || gnt[k]) wt[k] = 0;
                else if (gnt != 4'b0000) wt[k] = wt[k] + 1;
                if (wt[k] > worst) worst = wt[k];
            end
            chk("fair_wait", 32'(worst <= 3), 32'h1);
        end
        req = 4'b0000;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
